// File: rtl/snn_pkg.sv
// Shared definitions for the SNN output stage: steering codes and decoder state.
package snn_pkg;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_FWD   = 2'b11;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

endpackage

// File: rtl/snn_motor_decoder_if.sv
// Command channel from the rate decoder to the motor controller.
interface snn_motor_decoder_if #(
  parameter int unsigned EXCNUM = 2,
  parameter int unsigned CNT_W  = 11
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [EXCNUM*CNT_W-1:0]   cmd_count;
  logic [1:0]                cmd_dir;
  logic                      overrun;

  modport master (
    output cmd_valid,
    output cmd_count,
    output cmd_dir,
    output overrun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_count,
    input  cmd_dir,
    input  overrun,
    output cmd_ready
  );

endinterface

// File: rtl/snn_pwm_channel.sv
// One motor channel: duty register loaded from a window count, compared
// against the shared PWM counter.
module snn_pwm_channel #(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DUTY_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  input  logic [PWM_W-1:0] pwm_cnt_nxt,
  output logic             pwm_out
);

  localparam int unsigned MW = (CNT_W > PWM_W) ? CNT_W : PWM_W;
  localparam logic [MW-1:0] DUTY_MAX = MW'({PWM_W{1'b1}});

  logic [MW-1:0]    scaled_c;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  // Comparing against next-state values keeps pwm_out aligned with pwm_cnt/duty.
  always_comb begin
    scaled_c = MW'(count) >> DUTY_SHIFT;
    duty_d   = duty_q;
    if (load) begin
      duty_d = (scaled_c > DUTY_MAX) ? {PWM_W{1'b1}} : PWM_W'(scaled_c);
    end
    pwm_d = (pwm_cnt_nxt < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/snn_motor_decoder.sv
// Rate decoder: counts output spikes per window, latches counts and a steering
// decision for the motor controller, and drives per-channel PWM.
module snn_motor_decoder
  import snn_pkg::*;
#(
  parameter int unsigned EXCNUM     = 2,
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DUTY_SHIFT = 2,
  parameter int unsigned MIN_SPIKES = 4,
  parameter int unsigned DEADBAND   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [EXCNUM-1:0] spike_in,
  snn_motor_decoder_if.master cmd_if,
  output logic [EXCNUM-1:0] pwm_out
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]         cnt_q [EXCNUM];
  logic [CNT_W-1:0]         cnt_d [EXCNUM];
  logic [CNT_W-1:0]         cnt_inc_c [EXCNUM];
  logic [EXCNUM*CNT_W-1:0]  cmd_count_q, cmd_count_d;
  logic [1:0]               cmd_dir_q, cmd_dir_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     overrun_q, overrun_d;
  logic [PWM_W-1:0]         pwm_cnt_q, pwm_cnt_d;
  logic                     tick_c, win_end_c, xfer_c;

  function automatic logic [1:0] dir_of(input logic [CNT_W-1:0] c0,
                                        input logic [CNT_W-1:0] c1);
    logic [CNT_W-1:0] diff;
    diff = (c0 > c1) ? (c0 - c1) : (c1 - c0);
    if ((c0 < CNT_W'(MIN_SPIKES)) && (c1 < CNT_W'(MIN_SPIKES))) return DIR_STOP;
    if (diff <= CNT_W'(DEADBAND)) return DIR_FWD;
    if (c0 > c1) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

  // en gates every tick, so the IDLE->COUNT step never changes what a tick does.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    cnt_d       = cnt_q;
    cmd_count_d = cmd_count_q;
    cmd_dir_d   = cmd_dir_q;
    pwm_cnt_d   = pwm_cnt_q;
    tick_c      = en;
    win_end_c   = tick_c && (win_cnt_q == WIN_LAST);
    xfer_c      = cmd_valid_q && cmd_if.cmd_ready;

    for (int i = 0; i < EXCNUM; i++) begin
      cnt_inc_c[i] = (spike_in[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end

    if ((state_q == IDLE) && en) state_d = COUNT;

    if (tick_c) begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      if (win_end_c) begin
        win_cnt_d = '0;
        for (int i = 0; i < EXCNUM; i++) begin
          cnt_d[i]                        = '0;
          cmd_count_d[i*CNT_W +: CNT_W]   = cnt_inc_c[i];
        end
        cmd_dir_d = dir_of(cnt_inc_c[0], cnt_inc_c[1]);
      end else begin
        win_cnt_d = win_cnt_q + CNT_W'(1);
        cnt_d     = cnt_inc_c;
      end
    end

    // A window end always wins over a same-cycle transfer: new payload stays valid.
    cmd_valid_d = win_end_c ? 1'b1 : (xfer_c ? 1'b0 : cmd_valid_q);
    overrun_d   = overrun_q || (win_end_c && cmd_valid_q && !cmd_if.cmd_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      for (int i = 0; i < EXCNUM; i++) cnt_q[i] <= '0;
      cmd_count_q <= '0;
      cmd_dir_q   <= DIR_STOP;
      cmd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      pwm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      cnt_q       <= cnt_d;
      cmd_count_q <= cmd_count_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_valid_q <= cmd_valid_d;
      overrun_q   <= overrun_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < EXCNUM; i++) begin : g_ch
    snn_pwm_channel #(
      .CNT_W      (CNT_W),
      .PWM_W      (PWM_W),
      .DUTY_SHIFT (DUTY_SHIFT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .load        (win_end_c),
      .count       (cnt_inc_c[i]),
      .pwm_cnt_nxt (pwm_cnt_d),
      .pwm_out     (pwm_out[i])
    );
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_count = cmd_count_q;
  assign cmd_if.cmd_dir   = cmd_dir_q;
  assign cmd_if.overrun   = overrun_q;

endmodule

// File: tb/tb_snn_motor_decoder.sv
// Directed bench for snn_motor_decoder with a short window; a second instance
// with a 4-bit counter exercises saturation.
module tb_snn_motor_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cmd_ready;
  logic [1:0] spike_in;
  logic [1:0] pwm_out;
  logic [1:0] sat_pwm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snn_motor_decoder_if #(.EXCNUM(2), .CNT_W(11)) cmd_if ();
  snn_motor_decoder_if #(.EXCNUM(2), .CNT_W(4))  sat_if ();

  assign cmd_if.cmd_ready = cmd_ready;
  assign sat_if.cmd_ready = cmd_ready;

  snn_motor_decoder #(
    .EXCNUM(2), .WINDOW(16), .CNT_W(11), .PWM_W(8),
    .DUTY_SHIFT(0), .MIN_SPIKES(2), .DEADBAND(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cmd_if(cmd_if), .pwm_out(pwm_out)
  );

  snn_motor_decoder #(
    .EXCNUM(2), .WINDOW(16), .CNT_W(4), .PWM_W(8),
    .DUTY_SHIFT(0), .MIN_SPIKES(2), .DEADBAND(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cmd_if(sat_if), .pwm_out(sat_pwm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    spike_in  = 2'b00;
    cmd_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // One 16-tick window: channel i spikes on its first n_i ticks.
  task automatic run_window(input int n0, input int n1, input logic rdy_last);
    for (int t = 0; t < 16; t++) begin
      spike_in[0] = (t < n0);
      spike_in[1] = (t < n1);
      if (t == 15) cmd_ready = rdy_last;
      step();
    end
    spike_in = 2'b00;
  endtask

  function automatic logic [31:0] cnt0();
    return 32'(cmd_if.cmd_count[0 +: 11]);
  endfunction

  function automatic logic [31:0] cnt1();
    return 32'(cmd_if.cmd_count[11 +: 11]);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(cmd_if.cmd_valid), 32'd0);
    check({tag, "_count"},   32'(cmd_if.cmd_count), 32'd0);
    check({tag, "_dir"},     32'(cmd_if.cmd_dir),   32'd0);
    check({tag, "_overrun"}, 32'(cmd_if.overrun),   32'd0);
    check({tag, "_pwm"},     32'(pwm_out),          32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   hi0;
    logic hi1;

    // Reset then idle with en low
    do_reset();
    check_all_zero("reset");
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= cmd_if.cmd_valid;
    end
    check("idle_valid_never", 32'(seen), 32'd0);
    check_all_zero("idle_hold");

    // Continuous spikes on channel 0
    en = 1'b1; cmd_ready = 1'b1; spike_in = 2'b01;
    repeat (15) step();
    check("w1_valid_early", 32'(cmd_if.cmd_valid), 32'd0);
    step();
    check("w1_valid",   32'(cmd_if.cmd_valid), 32'd1);
    check("w1_cnt0",    cnt0(), 32'd16);
    check("w1_cnt1",    cnt1(), 32'd0);
    check("w1_dir",     32'(cmd_if.cmd_dir), 32'd1);
    check("w1_pwm",     32'(pwm_out), 32'd0);
    check("sat_valid",  32'(sat_if.cmd_valid), 32'd1);
    check("sat_cnt0",   32'(sat_if.cmd_count[3:0]), 32'd15);
    check("sat_dir",    32'(sat_if.cmd_dir), 32'd1);
    check("sat_ovr",    32'(sat_if.overrun), 32'd0);
    check("sat_pwm",    32'(sat_pwm), 32'd0);
    hi0 = 0; hi1 = 1'b0;
    step();
    check("w1_valid_drop", 32'(cmd_if.cmd_valid), 32'd0);
    hi0 += int'(pwm_out[0]); hi1 |= pwm_out[1];
    repeat (255) begin
      step();
      hi0 += int'(pwm_out[0]); hi1 |= pwm_out[1];
    end
    check("pwm0_high_ticks", 32'(hi0), 32'd16);
    check("pwm1_never",      32'(hi1), 32'd0);

    // Balanced, sparse, right-heavy windows; then window end coincident with transfer
    do_reset();
    en = 1'b1; cmd_ready = 1'b1;
    run_window(8, 7, 1'b1);
    check("bal_dir",  32'(cmd_if.cmd_dir), 32'd3);
    check("bal_cnt0", cnt0(), 32'd8);
    check("bal_cnt1", cnt1(), 32'd7);
    run_window(1, 1, 1'b1);
    check("sparse_dir", 32'(cmd_if.cmd_dir), 32'd0);
    run_window(3, 12, 1'b1);
    check("right_dir",  32'(cmd_if.cmd_dir), 32'd2);
    check("right_cnt1", cnt1(), 32'd12);
    cmd_ready = 1'b0;
    run_window(6, 6, 1'b1);
    check("coinc_valid",   32'(cmd_if.cmd_valid), 32'd1);
    check("coinc_cnt0",    cnt0(), 32'd6);
    check("coinc_overrun", 32'(cmd_if.overrun), 32'd0);
    step();
    check("coinc_drop",    32'(cmd_if.cmd_valid), 32'd0);

    // Overwrite with ready low
    do_reset();
    en = 1'b1; cmd_ready = 1'b0;
    run_window(5, 0, 1'b0);
    check("ovr_w1_cnt0",    cnt0(), 32'd5);
    check("ovr_w1_dir",     32'(cmd_if.cmd_dir), 32'd1);
    check("ovr_w1_overrun", 32'(cmd_if.overrun), 32'd0);
    run_window(9, 0, 1'b0);
    check("ovr_w2_cnt0",    cnt0(), 32'd9);
    check("ovr_w2_valid",   32'(cmd_if.cmd_valid), 32'd1);
    check("ovr_w2_overrun", 32'(cmd_if.overrun), 32'd1);
    en = 1'b0; cmd_ready = 1'b1;
    step();
    check("ovr_accept_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("ovr_sticky",       32'(cmd_if.overrun), 32'd1);

    // en dropped mid-window; spikes during the gap must be ignored
    do_reset();
    en = 1'b1; cmd_ready = 1'b1; spike_in = 2'b01;
    repeat (8) step();
    en = 1'b0; spike_in = 2'b11;
    repeat (5) step();
    check("gap_valid", 32'(cmd_if.cmd_valid), 32'd0);
    en = 1'b1; spike_in = 2'b01;
    repeat (7) step();
    check("gap_valid_early", 32'(cmd_if.cmd_valid), 32'd0);
    step();
    check("gap_valid_late", 32'(cmd_if.cmd_valid), 32'd1);
    check("gap_cnt0",       cnt0(), 32'd16);
    check("gap_cnt1",       cnt1(), 32'd0);

    // Reset mid-window with a pending command
    do_reset();
    en = 1'b1; cmd_ready = 1'b0; spike_in = 2'b01;
    repeat (16) step();
    check("rst_pending", 32'(cmd_if.cmd_valid), 32'd1);
    repeat (9) step();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (15) step();
    check("post_rst_early", 32'(cmd_if.cmd_valid), 32'd0);
    step();
    check("post_rst_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check("post_rst_cnt0",  cnt0(), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_motor_decoder.md
# snn_motor_decoder

Rate decoder at the output end of the SNN. It counts spikes from the excitatory output neurons over a fixed window of enabled cycles and latches per-channel spike counts plus a steering decision. The result is offered to the motor controller through a valid/ready handshake. Each channel also drives a PWM motor-drive pin whose duty tracks its latest spike rate.

## Interface
Parameters:
- EXCNUM, 2, number of output neurons and motor channels (channel 0 = Left, 1 = Right)
- WINDOW, 1024, enabled cycles per decode window; legal range 2..2^CNT_W
- CNT_W, 11, spike-counter width
- PWM_W, 8, PWM resolution
- DUTY_SHIFT, 2, right shift applied to a count to form its duty
- MIN_SPIKES, 4, below this on both channels the command is stop
- DEADBAND, 8, maximum |count0 - count1| still decoded as forward

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (clock clk)
- en  in  1  global enable, same signal as the SNN core
- spike_in  in  EXCNUM  output spikes from the excitatory neurons, one bit per channel
- cmd_ready  in  1  motor controller accepts the command
- cmd_valid  out  1  command payload valid
- cmd_count  out  EXCNUM*CNT_W  latched counts, channel i at bits [i*CNT_W +: CNT_W]
- cmd_dir  out  2  00 stop, 01 turn left, 10 turn right, 11 forward
- overrun  out  1  sticky flag: an unaccepted command was overwritten
- pwm_out  out  EXCNUM  per-channel PWM drive

## Operation
- States:
  - IDLE after reset; go to COUNT on the first cycle with en=1.
  - COUNT thereafter; return to IDLE only on rst.
- Tick definition: a tick is a cycle in COUNT, or an IDLE cycle with en=1. With en=0 nothing advances: window counter, spike counters, PWM counter and all outputs hold.
- Per tick:
  - win_cnt increments.
  - Each spike counter adds spike_in[i]. Counters saturate at 2^CNT_W-1.
- Window end (tick with win_cnt = WINDOW-1):
  - The spike on that tick is included.
  - Counts are latched to cmd_count.
  - Spike counters and win_cnt clear to 0.
- Direction, computed from the latched counts c0 and c1:
  - both below MIN_SPIKES: 00
  - else |c0-c1| <= DEADBAND: 11
  - else c0 > c1: 01
  - else: 10
- Duty: duty_i = min(c_i >> DUTY_SHIFT, 2^PWM_W-1), updated at window end.
- PWM:
  - Free-running PWM_W-bit counter, advancing on ticks.
  - pwm_out[i] = (pwm_cnt < duty_i).
  - New duty takes effect immediately; no wait for PWM period wrap.
- Handshake:
  - A transfer occurs when cmd_valid & cmd_ready.
  - Payload is stable while valid is high and not accepted.
  - cmd_ready is honoured regardless of en.
- Boundary conditions:
  - Window end with valid=1 and ready=0: payload is overwritten, valid stays 1, overrun is set.
  - Window end on the same cycle as a transfer: old payload is consumed, new payload loaded, valid stays 1, no overrun.
  - rst at any point clears every counter, payload, duty, overrun and valid.

## Timing
- Reset values: cmd_valid=0, cmd_count=0, cmd_dir=00, overrun=0, pwm_out=0.
- cmd_valid, cmd_count and cmd_dir register on the clock edge ending the window-end tick. They are visible 1 cycle after that tick.
- cmd_valid falls on the edge after the accepting cycle.
- duty_i, and hence pwm_out, update on the same edge as cmd_count.
- pwm_out is registered.
- overrun sets on the overwrite edge.
- spike_in is sampled synchronously; no combinational path from any input to any output.

## Structure
- Shared package snn_pkg holds:
  - dir encoding constants DIR_STOP, DIR_LEFT, DIR_RIGHT, DIR_FWD
  - state typedef {IDLE, COUNT}
- One sub-module, snn_pwm_channel: duty register plus comparator against the shared pwm_cnt. Instantiate EXCNUM times.
- Spike counters and direction logic stay in the top module.

## Test plan
All scenarios use WINDOW=16, DUTY_SHIFT=0, MIN_SPIKES=2, DEADBAND=2.
- Reset held 3 cycles then released with en=0 for 10 cycles -> all outputs 0, cmd_valid never rises.
- en=1, spike_in=01 every cycle, cmd_ready=1 -> cmd_valid=1 for one cycle, 1 cycle after the 16th tick. Payload: cmd_count={0,16}, cmd_dir=01. pwm_out[0] high 16 of each 256 ticks; pwm_out[1]=0.
- Balanced and sparse windows:
  - 8 spikes on ch0 and 7 on ch1 -> cmd_dir=11.
  - Next window 1 spike each -> cmd_dir=00.
  - Next window ch1=12, ch0=3 -> cmd_dir=10.
- cmd_ready=0 across two windows (5 then 9 spikes on ch0, none on ch1) -> cmd_count[ch0]=9 and overrun=1. Then cmd_ready=1 -> valid drops the next cycle; overrun stays 1.
- en dropped for 5 cycles mid-window -> cmd_valid rises 5 cycles later than uninterrupted; counts unchanged by the idle cycles. Plus ch0 saturation check with CNT_W=4, WINDOW=16 and spikes every tick -> count=15.
- rst asserted at tick 10 with pending valid -> next cycle all outputs 0. The next window counts from 0 and ends 16 ticks after release.
